lsu_seq: RTL and testbench

- Multi-cycle load/store sequencer between the core datapath and a handshaked data memory.
- Accepts one load/store op (encoded with the datapath pl_c code), checks alignment, drives a req/ack bus transaction, and stalls the core until completion.
- Returns a byte/half extracted and extended load result, or raises a fault.
- Adds wait-state tolerance and a bus-timeout guard so the core can use slow memory.

---
 rtl/lsu_seq_if.sv | 32 +++
 rtl/lsu_seq.sv | 180 ++++++++++++++++++
 tb/tb_lsu_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_seq_if.sv
// Core-side and data-memory-side signals of the load/store sequencer.
// The sequencer uses the master view; the core/memory environment uses the slave view.
interface lsu_seq_if;
  logic        op_valid;
  logic [2:0]  pl_c;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_code;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    input  op_valid, pl_c, addr, wdata, dm_ack, dm_rdata,
    output stall, done, rdata, fault, fault_code,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be
  );

  modport slave (
    output op_valid, pl_c, addr, wdata, dm_ack, dm_rdata,
    input  stall, done, rdata, fault, fault_code,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be
  );
endinterface

// File: rtl/lsu_seq.sv
// Multi-cycle load/store sequencer: alignment check, req/ack memory transaction,
// load extraction/extension, and a bus-timeout guard for slow memories.
module lsu_seq #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  lsu_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_op, w_op_nxt;
  logic [1:0]        r_lane, w_lane_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;
  logic              r_fault, w_fault_nxt;
  logic [1:0]        r_fault_code, w_fault_code_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              r_dm_req, w_dm_req_nxt;
  logic              r_dm_we, w_dm_we_nxt;
  logic [31:0]       r_dm_addr, w_dm_addr_nxt;
  logic [31:0]       r_dm_wdata, w_dm_wdata_nxt;
  logic [3:0]        r_dm_be, w_dm_be_nxt;

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_LW, OP_SW:         return lane != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lane[0];
      default:              return 1'b0;
    endcase
  endfunction

  // Lane selection uses the lane captured at issue, not the live address.
  function automatic logic [31:0] f_extract(input logic [2:0] op, input logic [1:0] lane,
                                            input logic [31:0] data);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    w_byte = 8'(data >> {lane, 3'b000});
    w_half = lane[1] ? data[31:16] : data[15:0];
    case (op)
      OP_LB:   return {{24{w_byte[7]}}, w_byte};
      OP_LBU:  return {24'h0, w_byte};
      OP_LH:   return {{16{w_half[15]}}, w_half};
      OP_LHU:  return {16'h0, w_half};
      default: return data;
    endcase
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_lane_nxt       = r_lane;
    w_cnt_nxt        = r_cnt;
    w_done_nxt       = 1'b0;
    w_fault_nxt      = 1'b0;
    w_fault_code_nxt = r_fault_code;
    w_rdata_nxt      = r_rdata;
    w_dm_req_nxt     = r_dm_req;
    w_dm_we_nxt      = r_dm_we;
    w_dm_addr_nxt    = r_dm_addr;
    w_dm_wdata_nxt   = r_dm_wdata;
    w_dm_be_nxt      = r_dm_be;
    case (r_state)
      IDLE: begin
        if (bus.op_valid) begin
          if (f_misaligned(bus.pl_c, bus.addr[1:0])) begin
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = 2'b01;
            w_state_nxt      = ERR;
          end else begin
            w_op_nxt      = bus.pl_c;
            w_lane_nxt    = bus.addr[1:0];
            w_dm_addr_nxt = {bus.addr[31:2], 2'b00};
            w_dm_req_nxt  = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = REQ;
            case (bus.pl_c)
              OP_SB: begin
                w_dm_we_nxt    = 1'b1;
                w_dm_wdata_nxt = {4{bus.wdata[7:0]}};
                w_dm_be_nxt    = 4'b0001 << bus.addr[1:0];
              end
              OP_SH: begin
                w_dm_we_nxt    = 1'b1;
                w_dm_wdata_nxt = {2{bus.wdata[15:0]}};
                w_dm_be_nxt    = 4'b0011 << bus.addr[1:0];
              end
              OP_SW: begin
                w_dm_we_nxt    = 1'b1;
                w_dm_wdata_nxt = bus.wdata;
                w_dm_be_nxt    = 4'hF;
              end
              default: begin
                w_dm_we_nxt    = 1'b0;
                w_dm_wdata_nxt = '0;
                w_dm_be_nxt    = 4'h0;
              end
            endcase
          end
        end
      end
      REQ: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (bus.dm_ack) begin
          w_dm_req_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = DONE;
          if (r_op < OP_SB) w_rdata_nxt = f_extract(r_op, r_lane, bus.dm_rdata);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (TIMEOUT != 0 && r_cnt == LP_LAST) begin
            w_dm_req_nxt     = 1'b0;
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = 2'b10;
            w_state_nxt      = ERR;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_lane       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= '0;
      r_rdata      <= '0;
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
      r_dm_be      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_lane       <= w_lane_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done       <= w_done_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
      r_rdata      <= w_rdata_nxt;
      r_dm_req     <= w_dm_req_nxt;
      r_dm_we      <= w_dm_we_nxt;
      r_dm_addr    <= w_dm_addr_nxt;
      r_dm_wdata   <= w_dm_wdata_nxt;
      r_dm_be      <= w_dm_be_nxt;
    end
  end

  assign bus.stall      = bus.op_valid & (r_state == IDLE || r_state == REQ);
  assign bus.done       = r_done;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.rdata      = r_rdata;
  assign bus.dm_req     = r_dm_req;
  assign bus.dm_we      = r_dm_we;
  assign bus.dm_addr    = r_dm_addr;
  assign bus.dm_wdata   = r_dm_wdata;
  assign bus.dm_be      = r_dm_be;
endmodule

// File: tb/tb_lsu_seq.sv
// Directed testbench for lsu_seq (TIMEOUT=4): loads, stores, alignment faults,
// bus timeout, reset during a transaction and back-to-back accesses.
module tb_lsu_seq;
  logic clk = 1'b0;
  logic rst;
  int   passCount  = 0;
  int   checkCount = 0;

  lsu_seq_if bus();

  lsu_seq #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                         SB = 3'd5, SH = 3'd6, SW = 3'd7;

  // Results of the most recent run_access call
  int          stallCycles, reqCycles, endCycle;
  logic        gotDone, gotFault, endStall, pulseAfter, stable;
  logic [1:0]  gotCode;
  logic [31:0] gotRdata;
  logic        snapWe;
  logic [3:0]  snapBe;
  logic [31:0] snapAddr, snapWdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and plays memory: ack is given in REQ cycle number waits+1.
  task automatic run_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] md, input int waits);
    stallCycles = 0; reqCycles = 0; endCycle = -1;
    gotDone = 1'b0; gotFault = 1'b0; gotCode = 2'b00; gotRdata = '0;
    endStall = 1'b1; stable = 1'b1;
    bus.op_valid = 1'b1; bus.pl_c = op; bus.addr = a; bus.wdata = wd; bus.dm_ack = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.fault) begin
        gotDone = bus.done; gotFault = bus.fault; gotCode = bus.fault_code;
        gotRdata = bus.rdata; endStall = bus.stall; endCycle = c;
        break;
      end
      if (bus.stall) stallCycles++;
      if (bus.dm_req) begin
        if (reqCycles == 0) begin
          snapWe = bus.dm_we; snapBe = bus.dm_be; snapAddr = bus.dm_addr; snapWdata = bus.dm_wdata;
        end else if ({bus.dm_we, bus.dm_be, bus.dm_addr, bus.dm_wdata} !==
                     {snapWe, snapBe, snapAddr, snapWdata}) begin
          stable = 1'b0;
        end
        reqCycles++;
        bus.dm_ack   = (reqCycles == waits + 1);
        bus.dm_rdata = bus.dm_ack ? md : 32'h0BAD_F00D;
      end else begin
        bus.dm_ack = 1'b0;
      end
      tick();
    end
    bus.op_valid = 1'b0;
    bus.dm_ack   = 1'b0;
    tick();
    pulseAfter = bus.done | bus.fault;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.pl_c = 3'd0; bus.addr = '0; bus.wdata = '0;
    bus.dm_ack = 1'b0; bus.dm_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checkCount++;
    if ({bus.done, bus.fault, bus.fault_code, bus.rdata, bus.dm_req, bus.dm_we,
         bus.dm_addr, bus.dm_wdata, bus.dm_be} !== '0)
      $display("[TB] FAIL reset_outputs: got req=%b done=%b fault=%b be=%h addr=%h want all zero",
               bus.dm_req, bus.done, bus.fault, bus.dm_be, bus.dm_addr);
    else passCount++;
    checkCount++;
    if (bus.stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", bus.stall);
    else passCount++;
  endtask

  task automatic test_lw();
    run_access(LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    checkCount++;
    if ({snapWe, snapBe, snapAddr} !== {1'b0, 4'h0, 32'h100})
      $display("[TB] FAIL lw_bus: got we=%b be=%h addr=%h want we=0 be=0 addr=00000100", snapWe, snapBe, snapAddr);
    else passCount++;
    checkCount++;
    if ({gotDone, gotFault, endCycle} !== {1'b1, 1'b0, 32'sd2})
      $display("[TB] FAIL lw_done: got done=%b fault=%b cycle=%0d want done=1 fault=0 cycle=2", gotDone, gotFault, endCycle);
    else passCount++;
    checkCount++;
    if (gotRdata !== 32'hDEAD_BEEF) $display("[TB] FAIL lw_rdata: got %h want deadbeef", gotRdata);
    else passCount++;
    checkCount++;
    if ({stallCycles, endStall} !== {32'sd2, 1'b0})
      $display("[TB] FAIL lw_stall: got %0d cycles, stall at done=%b want 2 cycles and 0", stallCycles, endStall);
    else passCount++;
    checkCount++;
    if ({reqCycles, pulseAfter} !== {32'sd1, 1'b0})
      $display("[TB] FAIL lw_req_pulse: got req=%0d pulse_after=%b want 1 and 0", reqCycles, pulseAfter);
    else passCount++;
  endtask

  task automatic test_loads();
    logic [2:0]  ops[6]  = '{LB, LBU, LH, LHU, LB, LH};
    logic [31:0] adrs[6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h201, 32'h200};
    logic [31:0] exps[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                             32'h0000_0012, 32'h0000_1234};
    for (int i = 0; i < 6; i++) begin
      run_access(ops[i], adrs[i], 32'h0, 32'h80FF_1234, 0);
      checkCount++;
      if ({gotDone, gotRdata, snapAddr} !== {1'b1, exps[i], 32'h200})
        $display("[TB] FAIL load_%0d: got done=%b rdata=%h addr=%h want done=1 rdata=%h addr=00000200",
                 i, gotDone, gotRdata, snapAddr, exps[i]);
      else passCount++;
    end
  endtask

  task automatic test_stores();
    run_access(LW, 32'h20, 32'h0, 32'h1357_9BDF, 0);
    run_access(SB, 32'h11, 32'h0000_00A5, 32'h0, 0);
    checkCount++;
    if ({snapWe, snapBe, snapWdata, snapAddr} !== {1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h10})
      $display("[TB] FAIL sb_bus: got we=%b be=%b wdata=%h addr=%h want 1 0010 a5a5a5a5 00000010",
               snapWe, snapBe, snapWdata, snapAddr);
    else passCount++;
    checkCount++;
    if ({gotDone, gotRdata} !== {1'b1, 32'h1357_9BDF})
      $display("[TB] FAIL sb_rdata_kept: got done=%b rdata=%h want 1 13579bdf", gotDone, gotRdata);
    else passCount++;
    run_access(SH, 32'h12, 32'h1234_BEEF, 32'h0, 0);
    checkCount++;
    if ({snapWe, snapBe, snapWdata, snapAddr} !== {1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h10})
      $display("[TB] FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h want 1 1100 beefbeef 00000010",
               snapWe, snapBe, snapWdata, snapAddr);
    else passCount++;
    run_access(SW, 32'h44, 32'hCAFE_F00D, 32'h0, 0);
    checkCount++;
    if ({snapWe, snapBe, snapWdata, snapAddr, gotDone} !== {1'b1, 4'hF, 32'hCAFE_F00D, 32'h44, 1'b1})
      $display("[TB] FAIL sw_bus: got we=%b be=%h wdata=%h addr=%h done=%b want 1 f cafef00d 00000044 1",
               snapWe, snapBe, snapWdata, snapAddr, gotDone);
    else passCount++;
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops[2]  = '{LW, SH};
    logic [31:0] adrs[2] = '{32'h102, 32'h101};
    for (int i = 0; i < 2; i++) begin
      run_access(ops[i], adrs[i], 32'h0, 32'h0, 0);
      checkCount++;
      if ({gotFault, gotDone, gotCode, reqCycles, endCycle} !== {1'b1, 1'b0, 2'b01, 32'sd0, 32'sd1})
        $display("[TB] FAIL misaligned_%0d: got fault=%b done=%b code=%b req=%0d cycle=%0d want 1 0 01 0 1",
                 i, gotFault, gotDone, gotCode, reqCycles, endCycle);
      else passCount++;
    end
    run_access(LB, 32'h103, 32'h0, 32'h7F00_0000, 0);
    checkCount++;
    if ({gotDone, gotFault, gotRdata, reqCycles} !== {1'b1, 1'b0, 32'h7F, 32'sd1})
      $display("[TB] FAIL lb_odd_ok: got done=%b fault=%b rdata=%h req=%0d want 1 0 0000007f 1",
               gotDone, gotFault, gotRdata, reqCycles);
    else passCount++;
  endtask

  task automatic test_timeout();
    run_access(LW, 32'h300, 32'h0, 32'h0, 99);
    checkCount++;
    if ({gotFault, gotDone, gotCode, reqCycles, endStall} !== {1'b1, 1'b0, 2'b10, 32'sd4, 1'b0})
      $display("[TB] FAIL timeout: got fault=%b done=%b code=%b req=%0d stall=%b want 1 0 10 4 0",
               gotFault, gotDone, gotCode, reqCycles, endStall);
    else passCount++;
    run_access(LW, 32'h304, 32'h0, 32'h55AA_55AA, 3);
    checkCount++;
    if ({gotDone, gotFault, gotRdata, reqCycles} !== {1'b1, 1'b0, 32'h55AA_55AA, 32'sd4})
      $display("[TB] FAIL ack_at_expiry: got done=%b fault=%b rdata=%h req=%0d want 1 0 55aa55aa 4",
               gotDone, gotFault, gotRdata, reqCycles);
    else passCount++;
    checkCount++;
    if (bus.fault_code !== 2'b10) $display("[TB] FAIL fault_code_hold: got %b want 10", bus.fault_code);
    else passCount++;
  endtask

  task automatic test_reset_in_req();
    logic sawActivity;
    bus.op_valid = 1'b1; bus.pl_c = LW; bus.addr = 32'h400; bus.dm_ack = 1'b0;
    tick();
    checkCount++;
    if (bus.dm_req !== 1'b1) $display("[TB] FAIL rst_req_setup: got dm_req=%b want 1", bus.dm_req);
    else passCount++;
    rst = 1'b1; bus.op_valid = 1'b0;
    tick();
    checkCount++;
    if ({bus.dm_req, bus.done, bus.fault} !== 3'b000)
      $display("[TB] FAIL rst_in_req: got req=%b done=%b fault=%b want 000", bus.dm_req, bus.done, bus.fault);
    else passCount++;
    rst = 1'b0;
    bus.dm_ack = 1'b1; bus.dm_rdata = 32'hFFFF_FFFF;
    sawActivity = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sawActivity = sawActivity | bus.dm_req | bus.done | bus.fault;
    end
    bus.dm_ack = 1'b0;
    checkCount++;
    if (sawActivity !== 1'b0) $display("[TB] FAIL idle_ack_ignored: got activity=%b want 0", sawActivity);
    else passCount++;
    run_access(LW, 32'h404, 32'h0, 32'h0F0F_0F0F, 0);
    checkCount++;
    if ({gotDone, gotRdata, snapAddr} !== {1'b1, 32'h0F0F_0F0F, 32'h404})
      $display("[TB] FAIL lw_after_rst: got done=%b rdata=%h addr=%h want 1 0f0f0f0f 00000404",
               gotDone, gotRdata, snapAddr);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    run_access(SW, 32'h80, 32'h1122_3344, 32'h0, 3);
    checkCount++;
    if ({gotDone, stable, reqCycles, stallCycles, snapBe, snapWdata} !==
        {1'b1, 1'b1, 32'sd4, 32'sd5, 4'hF, 32'h1122_3344})
      $display("[TB] FAIL b2b_sw: got done=%b stable=%b req=%0d stall=%0d be=%h wdata=%h want 1 1 4 5 f 11223344",
               gotDone, stable, reqCycles, stallCycles, snapBe, snapWdata);
    else passCount++;
    run_access(LW, 32'h80, 32'h0, 32'h1122_3344, 3);
    checkCount++;
    if ({gotDone, stable, reqCycles, gotRdata, snapWe, snapBe} !==
        {1'b1, 1'b1, 32'sd4, 32'h1122_3344, 1'b0, 4'h0})
      $display("[TB] FAIL b2b_lw: got done=%b stable=%b req=%0d rdata=%h we=%b be=%h want 1 1 4 11223344 0 0",
               gotDone, stable, reqCycles, gotRdata, snapWe, snapBe);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
